// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite slave with control registers, status/level readback and an instruction-push FIFO.
// Optional macro AXIL_SLVERR_EN: return SLVERR for unmapped, read-only-write and write-only-read accesses.
module axi_lite_if #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int NUM_CTRL_REGS   = 16,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [AXIL_ADDR_WIDTH-1:0]    AWADDR,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [AXIL_DATA_WIDTH-1:0]    WDATA,
    input  logic [AXIL_DATA_WIDTH/8-1:0]  WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [AXIL_ADDR_WIDTH-1:0]    ARADDR,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [AXIL_DATA_WIDTH-1:0]    RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    input  logic [31:0]                   status_in,
    output logic [NUM_CTRL_REGS*32-1:0]   ctrl_regs,
    output logic                          instr_valid,
    output logic [31:0]                   instr_data,
    input  logic                          instr_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [5:0] NREG = 6'(NUM_CTRL_REGS);

    logic              aw_held, w_held;
    logic [5:0]        aw_idx, ar_idx;
    logic [31:0]       w_data, rd_val;
    logic [3:0]        w_strb;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              full, is_push, commit, push, pop, aw_hs, w_hs, ar_hs, wr_err, rd_err;

    assign AWREADY     = ARESETn & !aw_held & !BVALID;
    assign WREADY      = ARESETn & !w_held & !BVALID;
    assign ARREADY     = ARESETn & !RVALID;
    assign aw_hs       = AWVALID & AWREADY;
    assign w_hs        = WVALID & WREADY;
    assign ar_hs       = ARVALID & ARREADY;
    assign ar_idx      = ARADDR[7:2];
    assign full        = level == LW'(FIFO_DEPTH);
    assign is_push     = aw_idx == 6'd18;
    // A push to a full FIFO waits here rather than dropping the word
    assign commit      = aw_held & w_held & !(is_push & full);
    assign push        = commit & is_push;
    assign pop         = instr_valid & instr_ready;
    assign instr_valid = level != '0;
    assign instr_data  = mem[rd_ptr];

`ifdef AXIL_SLVERR_EN
    assign wr_err = !(aw_idx < NREG || aw_idx == 6'd18);
    assign rd_err = !(ar_idx < NREG || ar_idx == 6'd16 || ar_idx == 6'd19 || ar_idx == 6'd20);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    always_comb begin
        rd_val = ar_idx < NREG    ? ctrl_regs[32*ar_idx[3:0] +: 32] :
                 ar_idx == 6'd16  ? status_in :
                 ar_idx == 6'd19  ? {31'b0, !full} :
                 ar_idx == 6'd20  ? {{(32-LW){1'b0}}, level} : 32'b0;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_idx    <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            BVALID    <= 1'b0;
            BRESP     <= 2'b00;
            ctrl_regs <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= AWADDR[7:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                BRESP   <= wr_err ? 2'b10 : 2'b00;
                if (aw_idx < NREG)
                    for (int b = 0; b < 4; b++)
                        if (w_strb[b]) ctrl_regs[32*aw_idx[3:0] + 8*b +: 8] <= w_data[8*b +: 8];
            end else if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= 2'b00;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RDATA  <= rd_val;
            RRESP  <= rd_err ? 2'b10 : 2'b00;
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= w_data;
    end
endmodule

// File: tb/tb_axi_lite_if.sv
// tb_axi_lite_if: randomized scenario bench for axi_lite_if against a register/queue reference model.
module tb_axi_lite_if;
    logic         ACLK = 1'b0;
    logic         ARESETn;
    logic [7:0]   AWADDR, ARADDR;
    logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]  WDATA, RDATA, status_in, instr_data;
    logic [3:0]   WSTRB;
    logic [1:0]   BRESP, RRESP;
    logic [511:0] ctrl_regs;
    logic         instr_valid, instr_ready;

    logic [31:0] model_regs [16];
    logic [31:0] model_q [$];
    int          pass_cnt = 0;
    int          total = 0;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    axi_lite_if dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .status_in(status_in), .ctrl_regs(ctrl_regs),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_f, w_f, b_f, done;
        resp = 2'b11;
        done = 1'b0;
        AWADDR = a; WDATA = d; WSTRB = s;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            b_f  = BVALID && BREADY;
            if (b_f) resp = BRESP;
            tick();
            if (aw_f) AWVALID = 1'b0;
            if (w_f) WVALID = 1'b0;
            if (b_f) done = 1'b1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL write_timeout addr=%h no BVALID handshake within 40 cycles", a);
        end
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic ar_f, r_f, done;
        d = 32'hxxxxxxxx;
        resp = 2'b11;
        done = 1'b0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            ar_f = ARVALID && ARREADY;
            r_f  = RVALID && RREADY;
            if (r_f) begin
                d = RDATA;
                resp = RRESP;
            end
            tick();
            if (ar_f) ARVALID = 1'b0;
            if (r_f) done = 1'b1;
        end
        ARVALID = 1'b0; RREADY = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL read_timeout addr=%h no RVALID handshake within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARVALID = 0; RREADY = 0; status_in = '0; instr_ready = 0;
        foreach (model_regs[i]) model_regs[i] = '0;
        repeat (3) tick();
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b000)
            $display("FAIL reset_ready got %b expected 000", {AWREADY, WREADY, ARREADY});
        else pass_cnt++;
        ARESETn = 1'b1;
        tick();
        total++;
        if ({BVALID, RVALID, instr_valid, BRESP, RRESP, RDATA} !== '0 || ctrl_regs !== '0)
            $display("FAIL reset_state got bv=%b rv=%b iv=%b bresp=%b rresp=%b rdata=%h ctrl_nonzero=%b expected all 0",
                     BVALID, RVALID, instr_valid, BRESP, RRESP, RDATA, ctrl_regs != '0);
        else pass_cnt++;
        total++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111)
            $display("FAIL idle_ready got %b expected 111", {AWREADY, WREADY, ARREADY});
        else pass_cnt++;
    endtask

    task automatic test_ctrl_regs();
        logic [1:0]  resp;
        logic [31:0] d, v;
        logic [3:0]  s;
        int          k;
        axi_write(8'h00, 32'hDEADBEEF, 4'hF, resp);
        model_regs[0] = 32'hDEADBEEF;
        axi_read(8'h00, d, v[1:0]);
        total++;
        if (d !== 32'hDEADBEEF || resp !== 2'b00 || v[1:0] !== 2'b00)
            $display("FAIL ctrl0_rw got data=%h bresp=%b rresp=%b expected DEADBEEF 00 00", d, resp, v[1:0]);
        else pass_cnt++;
        total++;
        if (ctrl_regs[31:0] !== 32'hDEADBEEF)
            $display("FAIL ctrl0_port got %h expected DEADBEEF", ctrl_regs[31:0]);
        else pass_cnt++;
        axi_write(8'h04, 32'hFFFFFFFF, 4'hF, resp);
        axi_write(8'h04, 32'h12345678, 4'h3, resp);
        model_regs[1] = 32'hFFFF5678;
        axi_read(8'h04, d, resp);
        total++;
        if (d !== 32'hFFFF5678)
            $display("FAIL ctrl1_strobe got %h expected FFFF5678", d);
        else pass_cnt++;
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 15);
            v = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(8'(k * 4), v, s, resp);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_regs[k][8*b +: 8] = v[8*b +: 8];
            k = $urandom_range(0, 15);
            axi_read(8'(k * 4), d, resp);
            total++;
            if (d !== model_regs[k] || resp !== 2'b00)
                $display("FAIL ctrl_rand reg=%0d got %h/%b expected %h/00", k, d, resp, model_regs[k]);
            else pass_cnt++;
        end
        foreach (model_regs[i]) begin
            axi_write(8'h40 + 8'(i % 4) * 8'h0C, $urandom, 4'hF, resp);
        end
        axi_write(8'h40, $urandom, 4'hF, resp);
        total++;
        if (resp !== ERR)
            $display("FAIL ro_write_resp got %b expected %b", resp, ERR);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (ctrl_regs[32*i +: 32] !== model_regs[i])
                $display("FAIL ctrl_port reg=%0d got %h expected %h", i, ctrl_regs[32*i +: 32], model_regs[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fifo();
        logic [1:0]  resp;
        logic [31:0] d, w;
        logic        seen;
        instr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            axi_write(8'h48, w, 4'($urandom_range(0, 15)), resp);
            model_q.push_back(w);
        end
        axi_read(8'h4C, d, resp);
        total++;
        if (d !== 32'd0) $display("FAIL can_accept_full got %h expected 0", d);
        else pass_cnt++;
        axi_read(8'h50, d, resp);
        total++;
        if (d !== 32'd16) $display("FAIL level_full got %0d expected 16", d);
        else pass_cnt++;
        axi_read(8'h48, d, resp);
        total++;
        if (d !== 32'd0 || resp !== ERR) $display("FAIL push_read got %h/%b expected 0/%b", d, resp, ERR);
        else pass_cnt++;
        w = $urandom;
        AWADDR = 8'h48; WDATA = w; WSTRB = 4'h0; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            seen |= BVALID;
            tick();
        end
        total++;
        if (seen) $display("FAIL push_full_stall got BVALID=1 expected 0");
        else pass_cnt++;
        total++;
        if (instr_data !== model_q[0]) $display("FAIL head_before_pop got %h expected %h", instr_data, model_q[0]);
        else pass_cnt++;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(w);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            if (BVALID) seen = 1'b1;
            else tick();
        end
        total++;
        if (!seen) $display("FAIL push_unblock got no BVALID expected BVALID");
        else pass_cnt++;
        tick();
        BREADY = 1'b0;
        axi_read(8'h50, d, resp);
        total++;
        if (d !== 32'd16) $display("FAIL level_after_unblock got %0d expected 16", d);
        else pass_cnt++;
        instr_ready = 1'b1;
        for (int n = 0; n < 40 && model_q.size() > 0; n++) begin
            total++;
            if (!instr_valid || instr_data !== model_q[0])
                $display("FAIL fifo_order got v=%b %h expected %h", instr_valid, instr_data, model_q[0]);
            else pass_cnt++;
            void'(model_q.pop_front());
            tick();
        end
        instr_ready = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || model_q.size() != 0)
            $display("FAIL fifo_drain got valid=%b left=%0d expected 0 0", instr_valid, model_q.size());
        else pass_cnt++;
    endtask

    task automatic test_split_order();
        logic [1:0]  resp;
        logic [31:0] d, v;
        for (int o = 0; o < 2; o++) begin
            v = $urandom;
            AWADDR = 8'h08; WDATA = v; WSTRB = 4'hF; BREADY = 1'b0;
            if (o == 0) AWVALID = 1'b1; else WVALID = 1'b1;
            tick();
            AWVALID = 1'b0; WVALID = 1'b0;
            repeat (2) tick();
            total++;
            if (BVALID !== 1'b0) $display("FAIL split_early order=%0d got BVALID=%b expected 0", o, BVALID);
            else pass_cnt++;
            if (o == 0) WVALID = 1'b1; else AWVALID = 1'b1;
            tick();
            AWVALID = 1'b0; WVALID = 1'b0;
            tick();
            model_regs[2] = v;
            for (int c = 0; c < 5; c++) begin
                total++;
                if ({BVALID, AWREADY, WREADY, BRESP} !== 5'b10000)
                    $display("FAIL bvalid_hold order=%0d cyc=%0d got bv/awr/wr/bresp=%b expected 10000",
                             o, c, {BVALID, AWREADY, WREADY, BRESP});
                else pass_cnt++;
                tick();
            end
            BREADY = 1'b1;
            tick();
            BREADY = 1'b0;
            repeat (3) tick();
            total++;
            if (BVALID !== 1'b0) $display("FAIL single_bvalid order=%0d got BVALID=%b expected 0", o, BVALID);
            else pass_cnt++;
            axi_read(8'h08, d, resp);
            total++;
            if (d !== model_regs[2]) $display("FAIL split_data order=%0d got %h expected %h", o, d, model_regs[2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_status();
        logic [1:0]  resp;
        logic [31:0] d;
        status_in = 32'hA5A50001;
        axi_read(8'h40, d, resp);
        total++;
        if (d !== 32'hA5A50001 || resp !== 2'b00) $display("FAIL status got %h/%b expected A5A50001/00", d, resp);
        else pass_cnt++;
        repeat (3) begin
            status_in = $urandom;
            axi_read(8'h40, d, resp);
            total++;
            if (d !== status_in) $display("FAIL status_rand got %h expected %h", d, status_in);
            else pass_cnt++;
        end
        axi_read(8'h7C, d, resp);
        total++;
        if (d !== 32'd0 || resp !== ERR) $display("FAIL unmapped_read got %h/%b expected 0/%b", d, resp, ERR);
        else pass_cnt++;
        axi_read(8'h4C, d, resp);
        total++;
        if (d !== 32'd1 || resp !== 2'b00) $display("FAIL can_accept_empty got %h/%b expected 1/00", d, resp);
        else pass_cnt++;
        axi_write(8'h7C, $urandom, 4'hF, resp);
        total++;
        if (resp !== ERR) $display("FAIL unmapped_write got %b expected %b", resp, ERR);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp;
        axi_write(8'h48, $urandom, 4'hF, resp);
        axi_write(8'h48, $urandom, 4'hF, resp);
        ARADDR = 8'h00; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        total++;
        if (RVALID !== 1'b1 || instr_valid !== 1'b1)
            $display("FAIL pre_reset got rvalid=%b ivalid=%b expected 1 1", RVALID, instr_valid);
        else pass_cnt++;
        ARESETn = 1'b0;
        #2;
        total++;
        if ({RVALID, instr_valid, ARREADY, AWREADY} !== 4'b0000)
            $display("FAIL mid_reset got rv/iv/arr/awr=%b expected 0000", {RVALID, instr_valid, ARREADY, AWREADY});
        else pass_cnt++;
        ARVALID = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        total++;
        if ({RVALID, instr_valid} !== 2'b00 || ctrl_regs !== '0)
            $display("FAIL post_reset got rv=%b iv=%b ctrl_nonzero=%b expected 0 0 0", RVALID, instr_valid, ctrl_regs != '0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_ctrl_regs();
        test_fifo();
        test_split_order();
        test_status();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/axi_lite_if.md
Name: axi_lite_if

Overview:
- AXI4-Lite slave front end of the neural-network accelerator; the host or sequencer writes (address, data) instruction pairs into it.
- Provides 16 read/write control registers, a status word and a push port into an instruction FIFO.
- The FIFO drains to the accelerator core through a valid/ready stream.
- A readable "can accept" flag lets the host poll before pushing.

Parameters:
AXIL_DATA_WIDTH, 32, data width; only 32 is supported.
AXIL_ADDR_WIDTH, 8, byte address width; decode uses ADDR[7:2].
NUM_CTRL_REGS, 16, control registers at 0x00–0x3C.
FIFO_DEPTH, 16, instruction FIFO entries; power of 2, at least 2.

Ports:
ACLK  in  1  clock, all logic on its rising edge
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  8  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  32  write data
WSTRB  in  4  write byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  8  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready
status_in  in  32  core status, readable at 0x40
ctrl_regs  out  NUM_CTRL_REGS*32  flat control registers; reg k is bits [32k+31:32k]
instr_valid  out  1  FIFO not empty
instr_data  out  32  FIFO head
instr_ready  in  1  core pops the head when high together with instr_valid

Behaviour:
Reset:
- BVALID, RVALID, all control registers, FIFO pointers, RDATA, BRESP and RRESP are all 0.
- AWREADY, WREADY and ARREADY are forced 0 while ARESETn is low.

Address map:
- 0x00–0x3C: control registers (R/W).
- 0x40: status_in (RO; writes ignored).
- 0x48: instruction push (WO; reads return 0).
- 0x4C: {31'b0, !fifo_full} (RO).
- 0x50: zero-extended FIFO level (RO).
- Any other address reads 0 and ignores writes.

Write channel:
- AW and W are accepted independently, in any order or in the same cycle.
- AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
- Commit happens on the first edge where aw_held & w_held are both set and the target is not (0x48 with FIFO full).
- On commit: the register or FIFO is updated, BVALID goes to 1 with BRESP=OKAY, and the held flags clear.
- Minimum latency: AW and W handshaken at edge N, BVALID high after edge N+1.
- BVALID holds until BREADY. No new AW or W is accepted while BVALID is high.
- Control-register writes honour WSTRB per byte. A push to 0x48 ignores WSTRB and stores the full WDATA.
- Push to 0x48 while the FIFO is full: commit stalls (no BVALID) until an entry pops, then completes. Nothing is dropped.
- Full is evaluated on registered state: a pop in the same cycle does not unblock the push until the next edge.

Read channel:
- ARREADY = !RVALID.
- After an AR handshake at edge N, RDATA, RVALID=1 and RRESP=OKAY are registered at that same edge.
- RDATA is sampled from pre-edge state, so a concurrent write or push is not visible in it.
- RVALID and RDATA hold until RREADY.

FIFO:
- Pop on instr_valid & instr_ready.
- Push and pop in the same cycle with the FIFO not full: level is unchanged.
- Level ranges 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.

Reset mid-transaction aborts all held AW/W/AR state and empties the FIFO.

Optional Feature:
- Macro: AXIL_SLVERR_EN.
- When defined: accesses to unmapped addresses return SLVERR (2'b10) on BRESP/RRESP. Writes to read-only 0x40, 0x4C and 0x50 also return SLVERR. Reads of write-only 0x48 also return SLVERR. Data behaviour is otherwise unchanged.
- When undefined: every response is OKAY.

Test Plan:
1. Reset, write 0x00=0xDEADBEEF with WSTRB=0xF, read 0x00 -> RDATA 0xDEADBEEF, BRESP/RRESP 0; ctrl_regs[31:0]=0xDEADBEEF.
2. Write 0x04=0xFFFFFFFF, then 0x04=0x12345678 with WSTRB=0x3 -> read returns 0xFFFF5678.
3. Hold instr_ready=0, push 16 words to 0x48 -> 0x4C reads 0 and 0x50 reads 16. A 17th push gets no BVALID. Pulse instr_ready for one cycle -> BVALID arrives, level stays 16, and instr_data order matches push order.
4. AW issued 3 cycles before W, and W before AW -> each produces a single BVALID; BREADY held low for 5 cycles -> BVALID stays high and AWREADY stays 0.
5. status_in=0xA5A5_0001, read 0x40 -> 0xA5A50001. Read 0x7C -> 0 (OKAY, or SLVERR with AXIL_SLVERR_EN).
6. Assert ARESETn low during an in-progress read -> RVALID drops to 0 and the FIFO empties (instr_valid=0).
